acc_ctrl_seq: RTL and testbench

- Control sequencer for the 8-bit accumulator processor.
- Fetches and decodes each instruction and sequences memory handshakes.
- Drives the 3-bit select of the accumulator-input 5:1 mux and the accumulator load strobe.
- Sits directly upstream of that mux: its mux_sel and acc_ld outputs choose and capture the accumulator's next value.

---
 rtl/acc_pkg.sv | 59 +++++
 rtl/acc_op_decode.sv | 44 ++++
 rtl/acc_ctrl_seq.sv | 150 +++++++++++++++
 tb/tb_acc_ctrl_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : acc_pkg
// Brief   : Shared opcode, mux-select, ALU-op and sequencer state encodings
//           for the 8-bit accumulator processor.
// Rev     : 1.0  initial release
// ============================================================================
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_IN   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JN   = 4'hC;
    localparam logic [3:0] OP_RSVD = 4'hD;
    localparam logic [3:0] OP_RSVE = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] SEL_ALU = 3'b000;
    localparam logic [2:0] SEL_MEM = 3'b001;
    localparam logic [2:0] SEL_IMM = 3'b010;
    localparam logic [2:0] SEL_IN  = 3'b011;
    localparam logic [2:0] SEL_PC  = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOT = 3'b100;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_EXEC = 3'd1,
        CL_MEM  = 3'd2,
        CL_JMP  = 3'd3,
        CL_JZ   = 3'd4,
        CL_JN   = 3'd5,
        CL_ILL  = 3'd6,
        CL_HLT  = 3'd7
    } op_class_t;

endpackage
`default_nettype wire

// File: rtl/acc_op_decode.sv
`default_nettype none
// ============================================================================
// Module  : acc_op_decode
// Brief   : Combinational opcode map to {class, mux_sel, alu_op, mem_we}.
// Rev     : 1.0  initial release
// ============================================================================
module acc_op_decode
    import acc_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] mux_sel,
    output logic [2:0] alu_op,
    output logic       mem_we
);

    always_comb begin
        op_class = CL_NOP;
        mux_sel  = SEL_ALU;
        alu_op   = ALU_ADD;
        mem_we   = 1'b0;
        unique case (opcode)
            OP_NOP:  op_class = CL_NOP;
            OP_LDI:  begin op_class = CL_EXEC; mux_sel = SEL_IMM; end
            OP_LD:   begin op_class = CL_MEM;  mux_sel = SEL_MEM; end
            OP_ST:   begin op_class = CL_MEM;  mem_we  = 1'b1;    end
            OP_ADD:  begin op_class = CL_MEM;  alu_op  = ALU_ADD; end
            OP_SUB:  begin op_class = CL_MEM;  alu_op  = ALU_SUB; end
            OP_AND:  begin op_class = CL_MEM;  alu_op  = ALU_AND; end
            OP_OR:   begin op_class = CL_MEM;  alu_op  = ALU_OR;  end
            OP_NOT:  begin op_class = CL_EXEC; alu_op  = ALU_NOT; end
            OP_IN:   begin op_class = CL_EXEC; mux_sel = SEL_IN;  end
            OP_JMP:  op_class = CL_JMP;
            OP_JZ:   op_class = CL_JZ;
            OP_JN:   op_class = CL_JN;
            OP_RSVD: op_class = CL_ILL;
            OP_RSVE: op_class = CL_ILL;
            OP_HLT:  op_class = CL_HLT;
            default: op_class = CL_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : acc_ctrl_seq
// Brief   : Fetch/decode/memory sequencer driving the accumulator mux and load
//           strobe. Optional mem_ack timeout: ACC_CTRL_MEM_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module acc_ctrl_seq
    import acc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr,
    input  logic       acc_zero,
    input  logic       acc_neg,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic [2:0] alu_op,
    output logic [2:0] mux_sel,
    output logic       acc_ld,
    output logic       halted,
    output logic       illegal
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("acc_ctrl_seq: TIMEOUT_CYCLES must be 1..255");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    op_class_t  w_class;
    logic [2:0] w_dec_sel;
    logic [2:0] w_dec_alu;
    logic       w_dec_we;
    logic       w_timeout;
    logic       w_unused_ok;

    assign w_unused_ok = &{1'b0, instr[3:0]};

    acc_op_decode u_dec (
        .opcode   (instr[7:4]),
        .op_class (w_class),
        .mux_sel  (w_dec_sel),
        .alu_op   (w_dec_alu),
        .mem_we   (w_dec_we)
    );

`ifdef ACC_CTRL_MEM_TIMEOUT_EN
    localparam logic [7:0] c_wait_limit = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait_cnt;

    // Any ack leaves FETCH/MEM, so clearing on "not waiting" covers entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (mem_req && !mem_ack) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    assign w_timeout = (r_wait_cnt == c_wait_limit);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are gated by rst_n so an asserted reset drops a request at once.
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_ld       = 1'b0;
        pc_inc      = 1'b0;
        pc_ld       = 1'b0;
        alu_op      = ALU_ADD;
        mux_sel     = SEL_ALU;
        acc_ld      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_ld   = mem_ack;
                    pc_inc  = mem_ack;
                    if (mem_ack) begin
                        w_state_nxt = ST_DECODE;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_DECODE: begin
                    w_state_nxt = ST_FETCH;
                    unique case (w_class)
                        CL_EXEC: w_state_nxt = ST_EXEC;
                        CL_MEM:  w_state_nxt = ST_MEM;
                        CL_JMP:  pc_ld = 1'b1;
                        CL_JZ:   pc_ld = acc_zero;
                        CL_JN:   pc_ld = acc_neg;
                        CL_ILL:  illegal = 1'b1;
                        CL_HLT:  w_state_nxt = ST_HALT;
                        default: w_state_nxt = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = w_dec_we;
                    if (mem_ack) begin
                        w_state_nxt = ST_FETCH;
                        if (!w_dec_we) begin
                            acc_ld  = 1'b1;
                            mux_sel = w_dec_sel;
                            alu_op  = w_dec_alu;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_EXEC: begin
                    acc_ld      = 1'b1;
                    mux_sel     = w_dec_sel;
                    alu_op      = w_dec_alu;
                    w_state_nxt = ST_FETCH;
                end
                ST_HALT: halted = 1'b1;
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_ctrl_seq
// Brief   : Cycle-trace bench for acc_ctrl_seq (directed table + random).
// Rev     : 1.0  initial release
// ============================================================================
module tb_acc_ctrl_seq;

    // {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, alu_op, mux_sel, acc_ld, halted, illegal}
    typedef struct packed {
        logic [7:0]  instr;
        logic        az;
        logic        an;
        logic        ack;
        logic [14:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       acc_zero = 1'b0;
    logic       acc_neg = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, halted, illegal;
    logic [2:0] alu_op, mux_sel;
    logic [14:0] got;

    int   checks = 0;
    int   errors = 0;
    vec_t q[$];

    acc_ctrl_seq #(.TIMEOUT_CYCLES(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .acc_zero (acc_zero),
        .acc_neg  (acc_neg),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .ir_ld    (ir_ld),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .alu_op   (alu_op),
        .mux_sel  (mux_sel),
        .acc_ld   (acc_ld),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    assign got = {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld,
                  alu_op, mux_sel, acc_ld, halted, illegal};

    function automatic logic [14:0] ev(input logic req, we, asel, irl, pci, pcl,
                                       input logic [2:0] alu, mux,
                                       input logic accl, hlt, ill);
        return {req, we, asel, irl, pci, pcl, alu, mux, accl, hlt, ill};
    endfunction

    task automatic check(input string nm, input int idx, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", nm, idx, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] ins, input logic az, an, ack,
                        input logic [14:0] exp);
        vec_t v;
        v.instr = ins; v.az = az; v.an = an; v.ack = ack; v.exp = exp;
        q.push_back(v);
    endtask

    // Expected cycle trace of one instruction, from FETCH back to the next FETCH.
    task automatic add_instr(input logic [3:0] op, input int fw, dw,
                             input logic az, an, spur);
        logic [7:0] ins;
        logic       pcl, ill, we, accl;
        logic [2:0] alu, mux;
        ins = {op, 4'($urandom)};
        for (int i = 0; i < fw; i++) push(ins, az, an, 1'b0, ev(1,0,0,0,0,0,3'd0,3'd0,0,0,0));
        push(ins, az, an, 1'b1, ev(1,0,0,1,1,0,3'd0,3'd0,0,0,0));
        pcl = (op == 4'hA) || (op == 4'hB && az) || (op == 4'hC && an);
        ill = (op == 4'hD) || (op == 4'hE);
        push(ins, az, an, spur, ev(0,0,0,0,0,pcl,3'd0,3'd0,0,0,ill));
        if (op >= 4'h2 && op <= 4'h7) begin
            we   = (op == 4'h3);
            accl = !we;
            mux  = (op == 4'h2) ? 3'b001 : 3'b000;
            alu  = (op >= 4'h4) ? 3'(op - 4'h4) : 3'b000;
            for (int i = 0; i < dw; i++) push(ins, az, an, 1'b0, ev(1,we,1,0,0,0,3'd0,3'd0,0,0,0));
            push(ins, az, an, 1'b1, ev(1,we,1,0,0,0,alu,mux,accl,0,0));
        end else if (op == 4'h1 || op == 4'h8 || op == 4'h9) begin
            mux = (op == 4'h1) ? 3'b010 : (op == 4'h9) ? 3'b011 : 3'b000;
            alu = (op == 4'h8) ? 3'b100 : 3'b000;
            push(ins, az, an, spur, ev(0,0,0,0,0,0,alu,mux,1,0,0));
        end
    endtask

    task automatic run_q(input string nm);
        for (int i = 0; i < q.size(); i++) begin
            instr = q[i].instr; acc_zero = q[i].az; acc_neg = q[i].an; mem_ack = q[i].ack;
            @(negedge clk);
            check(nm, i, q[i].exp);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    // Called 1 time unit after a rising edge; releases reset mid-cycle.
    task automatic do_reset(input string nm);
        rst_n = 1'b0; mem_ack = 1'b1; instr = 8'h25;
        #2;
        check(nm, 0, 15'd0);
        @(posedge clk);
        @(negedge clk);
        check(nm, 1, 15'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset");

        // Directed table: every opcode class and the branch conditions.
        add_instr(4'h1, 0, 0, 0, 0, 0);
        add_instr(4'h2, 1, 2, 0, 0, 1);
        add_instr(4'h3, 0, 1, 0, 0, 0);
        add_instr(4'h4, 0, 0, 0, 0, 0);
        add_instr(4'h5, 2, 0, 0, 0, 1);
        add_instr(4'h6, 0, 1, 0, 0, 0);
        add_instr(4'h7, 0, 0, 0, 0, 0);
        add_instr(4'h8, 0, 0, 0, 0, 1);
        add_instr(4'h9, 1, 0, 0, 0, 0);
        add_instr(4'hB, 0, 0, 1, 0, 0);
        add_instr(4'hB, 0, 0, 0, 1, 0);
        add_instr(4'hC, 0, 0, 0, 1, 0);
        add_instr(4'hC, 0, 0, 1, 0, 0);
        add_instr(4'hA, 0, 0, 0, 0, 1);
        add_instr(4'hD, 0, 0, 0, 0, 0);
        add_instr(4'hE, 0, 0, 0, 0, 1);
        add_instr(4'h0, 0, 0, 0, 0, 0);
        add_instr(4'h1, 0, 0, 0, 0, 0);
        run_q("directed");

        for (int n = 0; n < 60; n++)
            add_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
        run_q("random");

        // Reset asserted while a data request is outstanding.
        push(8'h25, 0, 0, 1'b1, ev(1,0,0,1,1,0,3'd0,3'd0,0,0,0));
        push(8'h25, 0, 0, 1'b0, ev(0,0,0,0,0,0,3'd0,3'd0,0,0,0));
        push(8'h25, 0, 0, 1'b0, ev(1,0,1,0,0,0,3'd0,3'd0,0,0,0));
        run_q("mem_wait");
        instr = 8'h25; mem_ack = 1'b0;
        check("mem_pre_rst", 0, ev(1,0,1,0,0,0,3'd0,3'd0,0,0,0));
        do_reset("rst_mid_mem");
        add_instr(4'h1, 0, 0, 0, 0, 0);
        run_q("after_rst");

`ifdef ACC_CTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) push(8'h10, 0, 0, 1'b0, ev(1,0,0,0,0,0,3'd0,3'd0,0,0,0));
        push(8'h10, 0, 0, 1'b0, ev(0,0,0,0,0,0,3'd0,3'd0,0,1,0));
        push(8'h10, 0, 0, 1'b1, ev(0,0,0,0,0,0,3'd0,3'd0,0,1,0));
        run_q("timeout");
        do_reset("rst_after_to");
`endif

        // HLT: halted stays up and later acks produce no strobes.
        add_instr(4'hF, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            push(8'h21, 1, 1, 1'(i % 2), ev(0,0,0,0,0,0,3'd0,3'd0,0,1,0));
        run_q("halt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
